// File: rtl/axis_hdr_splitter_pkg.sv
// Shared definitions for the l3fwd header split/deparse path: FSM states,
// residual byte computation and the tkeep byte counter.
package axis_hdr_splitter_pkg;

    typedef enum logic [1:0] {
        ST_HDR0,
        ST_HDR1,
        ST_BODY,
        ST_FLUSH
    } state_t;

    localparam int unsigned KEEP_MAX = 128;
    localparam int unsigned CNT_W    = 8;

    // Header bytes that spill from beat 1 past the first full beat.
    function automatic int unsigned hdr_residual(input int unsigned hdr_keep,
                                                 input int unsigned s_keep);
        return hdr_keep - s_keep;
    endfunction

    function automatic logic [CNT_W-1:0] keep_count(input logic [KEEP_MAX-1:0] keep);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            n = n + CNT_W'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_hdr_splitter_if.sv
// AXI-Stream bundle with master/slave modports; widths set per instance.
interface axis_hdr_splitter_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 4,
    parameter int unsigned USER_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_hdr_splitter_skid.sv
// Two-entry skid buffer with registered outputs and a registered input ready.
module axis_hdr_splitter_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             out_free;
    logic             in_fire;

    assign out_free = out_ready || !out_valid;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_fire;
                    if (in_fire) out_data <= in_data;
                end
            end else if (in_fire) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
            // Ready tracks whether the skid slot will be empty next cycle.
            in_ready <= out_free || (!skid_valid && !in_fire);
        end
    end
endmodule

// File: rtl/axis_hdr_splitter.sv
// Splits an AXI-Stream packet into one wide header word and a realigned payload.
// Optional macro AXIS_HDR_SPLIT_DROP_SHORT_EN drops packets shorter than the header.
module axis_hdr_splitter
    import axis_hdr_splitter_pkg::*;
#(
    parameter int unsigned S_DATA_WIDTH   = 512,
    parameter int unsigned S_KEEP_WIDTH   = S_DATA_WIDTH / 8,
    parameter int unsigned HDR_DATA_WIDTH = 560,
    parameter int unsigned HDR_KEEP_WIDTH = HDR_DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned DEST_WIDTH     = 4,
    parameter int unsigned USER_WIDTH     = 4
) (
    input  logic clk,
    input  logic rst,
    axis_hdr_splitter_if.slave  s_axis,
    axis_hdr_splitter_if.master m_axis_hdr,
    axis_hdr_splitter_if.master m_axis,
    output logic status_drop
);
    localparam int unsigned SB     = S_DATA_WIDTH;
    localparam int unsigned SK     = S_KEEP_WIDTH;
    localparam int unsigned R      = hdr_residual(HDR_KEEP_WIDTH, S_KEEP_WIDTH);
    localparam int unsigned RB     = R * 8;
    localparam int unsigned SIDE_W = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int unsigned PAY_W  = SB + SK + 1 + SIDE_W;

`ifdef AXIS_HDR_SPLIT_DROP_SHORT_EN
    localparam bit DROP_SHORT = 1'b1;
`else
    localparam bit DROP_SHORT = 1'b0;
`endif

    if (!(S_DATA_WIDTH < HDR_DATA_WIDTH && HDR_DATA_WIDTH <= 2 * S_DATA_WIDTH)) begin : g_bad_cfg
        $error("axis_hdr_splitter: HDR_DATA_WIDTH must lie in (S_DATA_WIDTH, 2*S_DATA_WIDTH]");
    end

    state_t                    state;
    logic [SB-1:0]             acc_data;
    logic [SK-1:0]             acc_keep;
    logic [SIDE_W-1:0]         side_q;
    logic [SB-1:0]             res_data;
    logic [CNT_W-1:0]          res_cnt;
    logic [HDR_DATA_WIDTH-1:0] hdr_data;
    logic [HDR_KEEP_WIDTH-1:0] hdr_keep;
    logic [SIDE_W-1:0]         hdr_side;
    logic                      hdr_valid;

    logic [CNT_W-1:0]  in_cnt;
    logic [SIDE_W-1:0] in_side;
    logic              hdr_free;
    logic              short_tail;
    logic              s_ready;
    logic              fire;

    logic              pay_valid;
    logic              pay_ready;
    logic [SB-1:0]     pay_data;
    logic [SK-1:0]     pay_keep;
    logic              pay_last;
    logic [SIDE_W-1:0] pay_side;
    logic [PAY_W-1:0]  pay_out;
    logic [SK-1:0]     ones;

    assign ones       = '1;
    assign in_cnt     = keep_count(KEEP_MAX'(s_axis.tkeep));
    assign in_side    = {s_axis.tid, s_axis.tdest, s_axis.tuser};
    assign hdr_free   = !hdr_valid || m_axis_hdr.tready;
    assign short_tail = in_cnt <= CNT_W'(R);
    assign fire       = s_axis.tvalid && s_ready;

    always_comb begin
        s_ready = 1'b0;
        unique case (state)
            ST_HDR0:  s_ready = pay_ready && (DROP_SHORT || hdr_free || !s_axis.tlast);
            ST_HDR1:  s_ready = pay_ready && hdr_free;
            ST_BODY:  s_ready = pay_ready;
            ST_FLUSH: s_ready = 1'b0;
            default:  s_ready = 1'b0;
        endcase
    end
    assign s_axis.tready = s_ready;

    always_comb begin
        pay_valid = 1'b0;
        pay_data  = '0;
        pay_keep  = '0;
        pay_last  = 1'b0;
        pay_side  = side_q;
        unique case (state)
            ST_HDR0: begin
                pay_side  = in_side;
                pay_valid = fire && s_axis.tlast && !DROP_SHORT;
                pay_last  = 1'b1;
            end
            ST_HDR1: begin
                pay_valid = fire && s_axis.tlast && short_tail &&
                            !(DROP_SHORT && in_cnt < CNT_W'(R));
                pay_last  = 1'b1;
            end
            ST_BODY: begin
                // Residual is always a full (SK-R)-byte run while in the body.
                pay_valid = fire;
                pay_data  = {s_axis.tdata[RB-1:0], res_data[SB-RB-1:0]};
                pay_keep  = {s_axis.tkeep[R-1:0], {(SK-R){1'b1}}};
                pay_last  = s_axis.tlast && short_tail;
            end
            ST_FLUSH: begin
                pay_valid = 1'b1;
                pay_data  = res_data;
                pay_keep  = ones >> (CNT_W'(SK) - res_cnt);
                pay_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HDR0;
            hdr_valid   <= 1'b0;
            status_drop <= 1'b0;
            res_data    <= '0;
            res_cnt     <= '0;
            acc_data    <= '0;
            acc_keep    <= '0;
            side_q      <= '0;
            hdr_data    <= '0;
            hdr_keep    <= '0;
            hdr_side    <= '0;
        end else begin
            status_drop <= 1'b0;
            if (hdr_valid && m_axis_hdr.tready) hdr_valid <= 1'b0;
            unique case (state)
                ST_HDR0: if (fire) begin
                    acc_data <= s_axis.tdata;
                    acc_keep <= s_axis.tkeep;
                    side_q   <= in_side;
                    if (!s_axis.tlast) begin
                        state <= ST_HDR1;
                    end else if (DROP_SHORT) begin
                        status_drop <= 1'b1;
                    end else begin
                        hdr_valid <= 1'b1;
                        hdr_data  <= HDR_DATA_WIDTH'(s_axis.tdata);
                        hdr_keep  <= HDR_KEEP_WIDTH'(s_axis.tkeep);
                        hdr_side  <= in_side;
                    end
                end
                ST_HDR1: if (fire) begin
                    res_data <= s_axis.tdata >> RB;
                    res_cnt  <= (in_cnt > CNT_W'(R)) ? in_cnt - CNT_W'(R) : '0;
                    if (DROP_SHORT && s_axis.tlast && in_cnt < CNT_W'(R)) begin
                        status_drop <= 1'b1;
                    end else begin
                        hdr_valid <= 1'b1;
                        hdr_data  <= {s_axis.tdata[RB-1:0], acc_data};
                        hdr_keep  <= {s_axis.tkeep[R-1:0], acc_keep};
                        hdr_side  <= side_q;
                    end
                    if (s_axis.tlast) state <= short_tail ? ST_HDR0 : ST_FLUSH;
                    else              state <= ST_BODY;
                end
                ST_BODY: if (fire) begin
                    res_data <= s_axis.tdata >> RB;
                    res_cnt  <= (in_cnt > CNT_W'(R)) ? in_cnt - CNT_W'(R) : '0;
                    if (s_axis.tlast) state <= short_tail ? ST_HDR0 : ST_FLUSH;
                end
                ST_FLUSH: if (pay_ready) state <= ST_HDR0;
                default: state <= ST_HDR0;
            endcase
        end
    end

    assign m_axis_hdr.tdata  = hdr_data;
    assign m_axis_hdr.tkeep  = hdr_keep;
    assign m_axis_hdr.tvalid = hdr_valid;
    assign m_axis_hdr.tlast  = 1'b1;
    assign {m_axis_hdr.tid, m_axis_hdr.tdest, m_axis_hdr.tuser} = hdr_side;

    axis_hdr_splitter_skid #(
        .WIDTH(PAY_W)
    ) u_pay_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({pay_data, pay_keep, pay_last, pay_side}),
        .in_valid (pay_valid),
        .in_ready (pay_ready),
        .out_data (pay_out),
        .out_valid(m_axis.tvalid),
        .out_ready(m_axis.tready)
    );

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = pay_out;

endmodule

// File: tb/tb_axis_hdr_splitter.sv
// Scoreboard bench for axis_hdr_splitter: expected header/payload words are
// queued when a packet is driven and compared as the outputs handshake.
module tb_axis_hdr_splitter;
    localparam int unsigned SW = 512;
    localparam int unsigned SK = 64;
    localparam int unsigned HW = 560;
    localparam int unsigned HK = 70;

`ifdef AXIS_HDR_SPLIT_DROP_SHORT_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct {
        logic [HW-1:0] data;
        logic [HK-1:0] keep;
        logic [15:0]   side;
    } hdr_exp_t;

    typedef struct {
        logic [SW-1:0] data;
        logic [SK-1:0] keep;
        logic          last;
        logic [15:0]   side;
    } pay_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic status_drop;
    always #5 clk = ~clk;

    axis_hdr_splitter_if #(.DATA_WIDTH(SW), .KEEP_WIDTH(SK), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4)) s_axis ();
    axis_hdr_splitter_if #(.DATA_WIDTH(HW), .KEEP_WIDTH(HK), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4)) m_axis_hdr ();
    axis_hdr_splitter_if #(.DATA_WIDTH(SW), .KEEP_WIDTH(SK), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4)) m_axis ();

    axis_hdr_splitter #(
        .S_DATA_WIDTH(SW), .S_KEEP_WIDTH(SK), .HDR_DATA_WIDTH(HW), .HDR_KEEP_WIDTH(HK),
        .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_axis),
        .m_axis_hdr (m_axis_hdr),
        .m_axis     (m_axis),
        .status_drop(status_drop)
    );

    hdr_exp_t hq[$];
    pay_exp_t pq[$];
    hdr_exp_t he;
    pay_exp_t pe;
    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int drop_exp = 0;
    int hdr_mode = 0;  // 0: always ready, 1: random, 2: held low
    int pay_mode = 0;
    bit aborted = 0;

    function automatic logic [HW-1:0] hmask(input logic [HK-1:0] k);
        logic [HW-1:0] m;
        for (int i = 0; i < HK; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [SW-1:0] pmask(input logic [SK-1:0] k);
        logic [SW-1:0] m;
        for (int i = 0; i < SK; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    initial begin
        m_axis_hdr.tready = 1'b0;
        m_axis.tready     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (hdr_mode)
                0:       m_axis_hdr.tready = 1'b1;
                1:       m_axis_hdr.tready = ($urandom_range(0, 9) < 6);
                default: m_axis_hdr.tready = 1'b0;
            endcase
            case (pay_mode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = ($urandom_range(0, 9) < 7);
                default: m_axis.tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (status_drop === 1'b1) drop_seen++;
            if (m_axis_hdr.tvalid && m_axis_hdr.tready) begin
                checks++;
                if (hq.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_unexpected got keep=%h want no header", m_axis_hdr.tkeep);
                end else begin
                    he = hq.pop_front();
                    if ((m_axis_hdr.tdata & hmask(he.keep)) !== he.data || m_axis_hdr.tkeep !== he.keep ||
                        m_axis_hdr.tlast !== 1'b1 ||
                        {m_axis_hdr.tid, m_axis_hdr.tdest, m_axis_hdr.tuser} !== he.side) begin
                        errors++;
                        $display("FAIL hdr_word got keep=%h side=%h last=%b data[127:0]=%h want keep=%h side=%h last=1 data[127:0]=%h",
                                 m_axis_hdr.tkeep, {m_axis_hdr.tid, m_axis_hdr.tdest, m_axis_hdr.tuser},
                                 m_axis_hdr.tlast, m_axis_hdr.tdata[127:0], he.keep, he.side, he.data[127:0]);
                    end
                end
            end
            if (m_axis.tvalid && m_axis.tready) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pay_unexpected got keep=%h last=%b want no beat", m_axis.tkeep, m_axis.tlast);
                end else begin
                    pe = pq.pop_front();
                    if ((m_axis.tdata & pmask(pe.keep)) !== pe.data || m_axis.tkeep !== pe.keep ||
                        m_axis.tlast !== pe.last || {m_axis.tid, m_axis.tdest, m_axis.tuser} !== pe.side) begin
                        errors++;
                        $display("FAIL pay_beat got keep=%h last=%b side=%h data[127:0]=%h want keep=%h last=%b side=%h data[127:0]=%h",
                                 m_axis.tkeep, m_axis.tlast, {m_axis.tid, m_axis.tdest, m_axis.tuser},
                                 m_axis.tdata[127:0], pe.keep, pe.last, pe.side, pe.data[127:0]);
                    end
                end
            end
        end
    end

    // Drives one packet; stop_beats > 0 truncates it and queues no expectations.
    task automatic send_pkt(input int len, input bit gaps, input int stop_beats);
        logic [7:0]  pb [0:1535];
        logic [15:0] side;
        hdr_exp_t    h;
        pay_exp_t    p;
        int nbeats, rem, off, n, wcyc;
        bit hs;
        if (aborted) return;
        side = 16'($urandom);
        for (int i = 0; i < 1536; i++) pb[i] = (i < len) ? 8'($urandom) : 8'h00;
        nbeats = (len + SK - 1) / SK;
        if (stop_beats == 0) begin
            if (DROP && len < HK) begin
                drop_exp++;
            end else begin
                h.data = '0;
                h.keep = '0;
                h.side = side;
                for (int i = 0; i < HK; i++) if (i < len) begin
                    h.data[i*8 +: 8] = pb[i];
                    h.keep[i] = 1'b1;
                end
                hq.push_back(h);
                rem = (len > HK) ? len - HK : 0;
                off = HK;
                if (rem == 0) begin
                    p.data = '0; p.keep = '0; p.last = 1'b1; p.side = side;
                    pq.push_back(p);
                end
                while (rem > 0) begin
                    n = (rem > SK) ? SK : rem;
                    p.data = '0;
                    p.keep = '0;
                    for (int i = 0; i < n; i++) begin
                        p.data[i*8 +: 8] = pb[off + i];
                        p.keep[i] = 1'b1;
                    end
                    rem -= n;
                    off += n;
                    p.last = (rem == 0);
                    p.side = side;
                    pq.push_back(p);
                end
            end
        end
        for (int b = 0; b < nbeats && (stop_beats == 0 || b < stop_beats); b++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < SK; i++) begin
                s_axis.tdata[i*8 +: 8] = pb[b*SK + i];
                s_axis.tkeep[i] = (b*SK + i < len);
            end
            s_axis.tlast  = (b == nbeats - 1);
            s_axis.tid    = side[15:8];
            s_axis.tdest  = side[7:4];
            s_axis.tuser  = side[3:0];
            s_axis.tvalid = 1'b1;
            hs = 1'b0;
            wcyc = 0;
            while (!hs) begin
                @(negedge clk);
                hs = s_axis.tready;
                @(posedge clk);
                #1;
                wcyc++;
                if (!hs && wcyc > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL s_ready_timeout got ready=0 for %0d cycles want handshake", wcyc);
                    aborted = 1;
                    s_axis.tvalid = 1'b0;
                    return;
                end
            end
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((hq.size() != 0 || pq.size() != 0) && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (hq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got hdr_left=%0d pay_left=%0d want 0 0", name, hq.size(), pq.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hdr_mode = 0;
        pay_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", s_axis.tready); end
        checks++;
        if (m_axis_hdr.tvalid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid got %b want 0", m_axis_hdr.tvalid); end
        checks++;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_pay_valid got %b want 0", m_axis.tvalid); end
        checks++;
        if (status_drop !== 1'b0) begin errors++; $display("FAIL reset_status_drop got %b want 0", status_drop); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL idle_s_tready got %b want 1", s_axis.tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        int lens[12] = '{200, 70, 40, 134, 135, 1, 64, 65, 69, 71, 128, 129};
        foreach (lens[i]) send_pkt(lens[i], 1'b0, 0);
        drain("directed");
        checks++;
        if (drop_seen !== drop_exp) begin
            errors++;
            $display("FAIL directed_drop_count got %0d want %0d", drop_seen, drop_exp);
        end
    endtask

    task automatic test_back_to_back;
        hdr_mode = 2;
        fork
            begin
                send_pkt(200, 1'b0, 0);
                send_pkt(200, 1'b0, 0);
            end
            begin
                repeat (15) @(posedge clk);
                @(negedge clk);
                checks++;
                if (!(s_axis.tvalid === 1'b1 && s_axis.tready === 1'b0)) begin
                    errors++;
                    $display("FAIL b2b_stall got valid=%b ready=%b want valid=1 ready=0", s_axis.tvalid, s_axis.tready);
                end
                checks++;
                if (m_axis_hdr.tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_hdr_held got %b want 1", m_axis_hdr.tvalid);
                end
                repeat (5) @(posedge clk);
                #1;
                hdr_mode = 0;
            end
        join
        drain("back_to_back");
    endtask

    task automatic test_random;
        hdr_mode = 1;
        pay_mode = 1;
        for (int k = 0; k < 1000; k++) send_pkt($urandom_range(1, 1500), 1'b1, 0);
        drain("random");
        checks++;
        if (drop_seen !== drop_exp) begin
            errors++;
            $display("FAIL random_drop_count got %0d want %0d", drop_seen, drop_exp);
        end
        hdr_mode = 0;
        pay_mode = 0;
    endtask

    task automatic test_reset_mid_packet;
        hdr_mode = 2;
        pay_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(200, 1'b0, 2);
        @(negedge clk);
        checks++;
        if (m_axis_hdr.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_hdr_pending got %b want 1", m_axis_hdr.tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_hdr.tvalid !== 1'b0 || m_axis.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_invalidate got hdr=%b pay=%b want 0 0", m_axis_hdr.tvalid, m_axis.tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        hdr_mode = 0;
        pay_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(135, 1'b0, 0);
        drain("after_reset");
    endtask

    initial begin
        rst = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tid    = '0;
        s_axis.tdest  = '0;
        s_axis.tuser  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
